// File: rtl/alu_exec_ctrl.sv
// Issue/sequencing controller for the 16-bit ALU: accepts one op over valid/ready, holds the
// ALU ctrl code for the op latency, captures the results and writes them back through the
// single register-file port (MUL/DIV write a second word to R0). Bad ops are trapped early.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new op
// EXEC   | ALU driven with latched code; cnt counts down to terminal 0
// WB_LO  | write res_lo to the latched destination
// WB_HI  | write res_hi (MUL high / DIV remainder) to R0
// EXC    | one-cycle exception pulse (overflow, divide-by-zero, illegal)
module alu_exec_ctrl #(
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4,
    parameter int R0_ADDR = 0,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_code,
    input  logic [AW-1:0] op_dest,
    input  logic          op_b_zero,
    output logic [3:0]    alu_ctrl,
    input  logic [15:0]   alu_out,
    input  logic [15:0]   alu_r0,
    input  logic          alu_ovf,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [15:0]   rf_wdata,
    output logic          exc_valid,
    output logic [1:0]    exc_code,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_WB_LO = 3'd2,
        S_WB_HI = 3'd3,
        S_EXC   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      code_q;
    logic [AW-1:0]   dest_q;
    logic            bz_q;
    logic [15:0]     res_lo;
    logic [15:0]     res_hi;
    logic            ovf_q;
    logic            wide_q;
    logic            accept;

    function automatic logic is_legal(input logic [3:0] c);
        return (c == 4'h1) || (c == 4'h2) || (c == 4'h4) || (c == 4'h8) ||
               (c == 4'hC) || (c == 4'hE) || (c == 4'hF);
    endfunction

    // Counter preload is latency minus one so the terminal compare is against zero.
    function automatic logic [3:0] lat_m1(input logic [3:0] c);
        if (c == 4'h4)      return 4'(MUL_CYC - 1);
        else if (c == 4'h8) return 4'(DIV_CYC - 1);
        else                return 4'h0;
    endfunction

    assign accept = op_valid && (state == S_IDLE);
    assign wide_q = (code_q == 4'h4) || (code_q == 4'h8);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    if ((op_code == 4'h8) && op_b_zero) state_nxt = S_EXC;
                    else if (!is_legal(op_code))       state_nxt = S_EXC;
                    else                               state_nxt = S_EXEC;
                end
            end
            S_EXEC:  if (cnt == 4'h0) state_nxt = S_WB_LO;
            S_WB_LO: begin
                if (wide_q)     state_nxt = S_WB_HI;
                else if (ovf_q) state_nxt = S_EXC;
                else            state_nxt = S_IDLE;
            end
            S_WB_HI: state_nxt = S_IDLE;
            S_EXC:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Op latch, latency down-counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 4'h0;
            code_q <= 4'h0;
            dest_q <= '0;
            bz_q   <= 1'b0;
            res_lo <= 16'h0;
            res_hi <= 16'h0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            code_q <= op_code;
            dest_q <= op_dest;
            bz_q   <= op_b_zero;
            cnt    <= lat_m1(op_code);
            ovf_q  <= 1'b0;
        end else if (state == S_EXEC) begin
            if (cnt == 4'h0) begin
                res_lo <= alu_out;
                res_hi <= alu_r0;
                ovf_q  <= alu_ovf;
            end else begin
                cnt <= cnt - 4'h1;
            end
        end
    end

    // Outputs decode from registered state and latched regs only.
    always_comb begin
        op_ready  = 1'b0;
        busy      = 1'b1;
        alu_ctrl  = 4'h0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = 16'h0;
        exc_valid = 1'b0;
        exc_code  = 2'b00;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            S_EXEC: alu_ctrl = code_q;
            S_WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = res_lo;
            end
            S_WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = AW'(R0_ADDR);
                rf_wdata = res_hi;
            end
            S_EXC: begin
                exc_valid = 1'b1;
                if ((code_q == 4'h8) && bz_q) exc_code = 2'b10;
                else if (!is_legal(code_q))   exc_code = 2'b11;
                else                          exc_code = 2'b01;
            end
            default: ;
        endcase
    end

endmodule
